// File: rtl/tile_plot_arbiter.sv
// tile_plot_arbiter: round-robin arbiter that fills a square tile for one
// of two requesters (clear / draw) by plotting one pixel per cycle.
//
// Parameters:
//   TILE_LOG2     - tile edge is 2^TILE_LOG2 pixels
//   BORDER_COLOUR - border colour for draw tiles (TILE_BORDER_EN only)
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   clr_req, clr_x0, clr_y0  - clear request (fills colour 0)
//   drw_req, drw_x0, drw_y0,
//   drw_colour               - draw request and fill colour
//   clr_ack, drw_ack         - one-cycle completion pulse
//   x, y, colour, plot       - pixel write to the VGA adapter
//   busy                     - high whenever not idle
// Optional build macro:
//   TILE_BORDER_EN - draw tiles get a one-pixel BORDER_COLOUR frame
module tile_plot_arbiter #(
    parameter int         TILE_LOG2     = 4,
    parameter logic [2:0] BORDER_COLOUR = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_req,
    input  logic [7:0] clr_x0,
    input  logic [6:0] clr_y0,
    input  logic       drw_req,
    input  logic [7:0] drw_x0,
    input  logic [6:0] drw_y0,
    input  logic [2:0] drw_colour,
    output logic       clr_ack,
    output logic       drw_ack,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam int CW = 2 * TILE_LOG2;
    localparam logic [CW-1:0] LAST = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        PLOT,
        DONE
    } state_t;

    state_t        r_state;
    logic          r_last_clr;
    logic          r_win_clr;
    logic [7:0]    r_x0;
    logic [6:0]    r_y0;
    logic [2:0]    r_col;
    logic [CW-1:0] r_cnt;

    logic          w_grant_clr;
    logic [7:0]    w_gx0;
    logic [6:0]    w_gy0;
    logic [2:0]    w_gcol;
    logic [CW-1:0] w_cnt_nxt;
    logic [7:0]    w_x_nxt;
    logic [6:0]    w_y_nxt;
    logic [2:0]    w_px_g;
    logic [2:0]    w_px_n;

    // On a tie, clr wins unless it was the one served last.
    assign w_grant_clr = clr_req & (~drw_req | ~r_last_clr);
    assign w_gx0       = w_grant_clr ? clr_x0 : drw_x0;
    assign w_gy0       = w_grant_clr ? clr_y0 : drw_y0;
    assign w_gcol      = w_grant_clr ? 3'b000 : drw_colour;

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_x_nxt   = r_x0 + 8'(w_cnt_nxt[TILE_LOG2-1:0]);
    assign w_y_nxt   = r_y0 + 7'(w_cnt_nxt[CW-1:TILE_LOG2]);

`ifdef TILE_BORDER_EN
    logic [TILE_LOG2-1:0] w_lo;
    logic [TILE_LOG2-1:0] w_hi;
    logic                 w_edge_n;

    assign w_lo     = w_cnt_nxt[TILE_LOG2-1:0];
    assign w_hi     = w_cnt_nxt[CW-1:TILE_LOG2];
    assign w_edge_n = (w_lo == '0) || (w_lo == '1) ||
                      (w_hi == '0) || (w_hi == '1);
    assign w_px_n   = (!r_win_clr && w_edge_n) ? BORDER_COLOUR : r_col;
    // Pixel 0 is always a corner, hence always border on a draw tile.
    assign w_px_g   = w_grant_clr ? 3'b000 : BORDER_COLOUR;
`else
    logic w_unused;

    assign w_unused = ^BORDER_COLOUR;
    assign w_px_n   = r_col;
    assign w_px_g   = w_gcol;
`endif

    // Outputs are registered: each edge loads the pixel for the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last_clr <= 1'b0;
            r_win_clr  <= 1'b0;
            r_x0       <= '0;
            r_y0       <= '0;
            r_col      <= '0;
            r_cnt      <= '0;
            clr_ack    <= 1'b0;
            drw_ack    <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    clr_ack <= 1'b0;
                    drw_ack <= 1'b0;
                    if (clr_req || drw_req) begin
                        r_x0       <= w_gx0;
                        r_y0       <= w_gy0;
                        r_col      <= w_gcol;
                        r_win_clr  <= w_grant_clr;
                        r_last_clr <= w_grant_clr;
                        r_cnt      <= '0;
                        x          <= w_gx0;
                        y          <= w_gy0;
                        colour     <= w_px_g;
                        plot       <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= PLOT;
                    end
                end
                PLOT: begin
                    if (r_cnt == LAST) begin
                        plot    <= 1'b0;
                        clr_ack <= r_win_clr;
                        drw_ack <= ~r_win_clr;
                        r_state <= DONE;
                    end else begin
                        r_cnt  <= w_cnt_nxt;
                        x      <= w_x_nxt;
                        y      <= w_y_nxt;
                        colour <= w_px_n;
                    end
                end
                DONE: begin
                    clr_ack <= 1'b0;
                    drw_ack <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_plot_arbiter.sv
// tb_tile_plot_arbiter: scoreboard bench for tile_plot_arbiter.
// Expected pixels/acks are queued at stimulus time and popped on output.
module tb_tile_plot_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr_req;
    logic [7:0] clr_x0;
    logic [6:0] clr_y0;
    logic       drw_req;
    logic [7:0] drw_x0;
    logic [6:0] drw_y0;
    logic [2:0] drw_colour;
    logic       clr_ack;
    logic       drw_ack;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    always #5 clk = ~clk;

    tile_plot_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (clr_req),
        .clr_x0     (clr_x0),
        .clr_y0     (clr_y0),
        .drw_req    (drw_req),
        .drw_x0     (drw_x0),
        .drw_y0     (drw_y0),
        .drw_colour (drw_colour),
        .clr_ack    (clr_ack),
        .drw_ack    (drw_ack),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [17:0] sb_pix[$];
    logic [1:0]  sb_ack[$];
    int          pix_seen = 0;
    bit          grab = 0;
    logic [2:0]  c05 = 3'b000;
    logic [2:0]  c55 = 3'b000;
    logic [2:0]  cff = 3'b000;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_tile(input logic [7:0] x0, input logic [6:0] y0,
                             input logic [2:0] col, input bit is_clr,
                             input int npix, input bit with_ack);
        for (int i = 0; i < npix; i++) begin
            logic [7:0] px;
            logic [6:0] py;
            logic [3:0] lo;
            logic [3:0] hi;
            logic [2:0] c;
            lo = i[3:0];
            hi = i[7:4];
            px = x0 + {4'b0000, lo};
            py = y0 + {3'b000, hi};
            c  = is_clr ? 3'b000 : col;
`ifdef TILE_BORDER_EN
            if (!is_clr && (lo == 0 || lo == 15 || hi == 0 || hi == 15))
                c = 3'b111;
`endif
            sb_pix.push_back({px, py, c});
        end
        if (with_ack)
            sb_ack.push_back(is_clr ? 2'b10 : 2'b01);
    endtask

    always @(negedge clk) begin
        if (plot) begin
            pix_seen++;
            if (sb_pix.size() == 0)
                chk("extra_plot", sb_pix.size(), 1);
            else
                chk("pix", {x, y, colour}, sb_pix.pop_front());
            if (grab && x == 8'd0 && y == 7'd5)   c05 = colour;
            if (grab && x == 8'd5 && y == 7'd5)   c55 = colour;
            if (grab && x == 8'd15 && y == 7'd15) cff = colour;
        end
        if (clr_ack || drw_ack) begin
            if (sb_ack.size() == 0)
                chk("extra_ack", sb_ack.size(), 1);
            else
                chk("ack", {clr_ack, drw_ack}, sb_ack.pop_front());
        end
    end

    task automatic wait_ack(input bit is_drw, output int cyc);
        bit got;
        got = 0;
        cyc = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            cyc++;
            if (is_drw ? drw_ack : clr_ack) begin
                got = 1;
                break;
            end
        end
        chk(is_drw ? "drw_ack_wait" : "clr_ack_wait", got, 1);
        @(posedge clk);
        #1;
        if (is_drw) drw_req = 1'b0;
        else        clr_req = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        clr_req = 1'b0;
        drw_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int cyc;

    initial begin
        reset      = 1'b1;
        clr_req    = 1'b0;
        clr_x0     = '0;
        clr_y0     = '0;
        drw_req    = 1'b0;
        drw_x0     = '0;
        drw_y0     = '0;
        drw_colour = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", {clr_ack, drw_ack}, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_col", colour, 0);
        reset = 1'b0;

        // single clear, latency and held outputs
        push_tile(8'd10, 7'd20, 3'b000, 1, 256, 1);
        clr_x0  = 8'd10;
        clr_y0  = 7'd20;
        clr_req = 1'b1;
        wait_ack(0, cyc);
        chk("clr_latency", cyc, 258);
        @(negedge clk);
        chk("x_hold", x, 25);
        chk("y_hold", y, 35);
        chk("idle_busy", busy, 0);
        chk("idle_plot", plot, 0);

        // simultaneous requests after reset
        do_reset();
        push_tile(8'd1, 7'd2, 3'b000, 1, 256, 1);
        push_tile(8'd3, 7'd4, 3'b101, 0, 256, 1);
        clr_x0     = 8'd1;
        clr_y0     = 7'd2;
        drw_x0     = 8'd3;
        drw_y0     = 7'd4;
        drw_colour = 3'b101;
        clr_req    = 1'b1;
        drw_req    = 1'b1;
        wait_ack(0, cyc);
        @(negedge clk);
        chk("gap_busy", busy, 0);
        @(negedge clk);
        chk("gap_plot", plot, 1);
        wait_ack(1, cyc);
        push_tile(8'd6, 7'd7, 3'b000, 1, 256, 1);
        push_tile(8'd8, 7'd9, 3'b110, 0, 256, 1);
        clr_x0     = 8'd6;
        clr_y0     = 7'd7;
        drw_x0     = 8'd8;
        drw_y0     = 7'd9;
        drw_colour = 3'b110;
        clr_req    = 1'b1;
        drw_req    = 1'b1;
        wait_ack(0, cyc);
        wait_ack(1, cyc);

        // wrap-around
        push_tile(8'd250, 7'd120, 3'b010, 0, 256, 1);
        drw_x0     = 8'd250;
        drw_y0     = 7'd120;
        drw_colour = 3'b010;
        drw_req    = 1'b1;
        wait_ack(1, cyc);

        // reset mid-tile at count 100
        push_tile(8'd30, 7'd40, 3'b011, 0, 101, 0);
        pix_seen   = 0;
        drw_x0     = 8'd30;
        drw_y0     = 7'd40;
        drw_colour = 3'b011;
        drw_req    = 1'b1;
        for (int n = 0; n < 300 && pix_seen < 101; n++) begin
            @(negedge clk);
            #1;
        end
        chk("abort_reach", pix_seen, 101);
        reset   = 1'b1;
        drw_req = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ack", {clr_ack, drw_ack}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_sb", sb_pix.size(), 0);
        push_tile(8'd30, 7'd40, 3'b011, 0, 256, 1);
        drw_req = 1'b1;
        wait_ack(1, cyc);

        // draw pulse during a clear is ignored
        push_tile(8'd0, 7'd0, 3'b000, 1, 256, 1);
        clr_x0     = 8'd0;
        clr_y0     = 7'd0;
        drw_x0     = 8'd5;
        drw_y0     = 7'd5;
        drw_colour = 3'b100;
        clr_req    = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        drw_req = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        drw_req = 1'b0;
        wait_ack(0, cyc);
        repeat (5) @(negedge clk);
        chk("no_drw_grant", busy, 0);

        // border / uniform colour
        grab = 1;
        push_tile(8'd0, 7'd0, 3'b001, 0, 256, 1);
        drw_x0     = 8'd0;
        drw_y0     = 7'd0;
        drw_colour = 3'b001;
        drw_req    = 1'b1;
        wait_ack(1, cyc);
        grab = 0;
`ifdef TILE_BORDER_EN
        chk("px_0_5", c05, 7);
        chk("px_5_5", c55, 1);
        chk("px_15_15", cff, 7);
`else
        chk("px_0_5", c05, 1);
        chk("px_5_5", c55, 1);
        chk("px_15_15", cff, 1);
`endif

        repeat (3) @(negedge clk);
        chk("sb_pix_left", sb_pix.size(), 0);
        chk("sb_ack_left", sb_ack.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
